// File: rtl/dma_mem_responder.sv
// Slave-side line-memory endpoint for the dma_* burst interface.
// Serves read bursts and absorbs byte-strobed write bursts on independent channels.
module dma_mem_responder #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MEM_AW             = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dma_rd_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   dma_rd_addr,
    input  logic [7:0]                      dma_rd_len,
    output logic                            dma_rd_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   dma_rd_data,
    output logic                            dma_rd_data_valid,
    output logic                            dma_rd_data_last,
    input  logic                            dma_rd_data_taken,
    input  logic                            dma_wr_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   dma_wr_addr,
    input  logic [7:0]                      dma_wr_len,
    output logic                            dma_wr_req_ack,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   dma_wr_data,
    input  logic                            dma_wr_wvalid,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] dma_wr_data_strobe,
    input  logic                            dma_wr_data_last,
    output logic                            dma_wr_ready,
    input  logic                            dma_wr_bready,
    output logic                            dma_wr_done,
    output logic                            proto_err
);
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_DATA, W_RESP} wr_state_e;

    logic [DW-1:0] mem [DEPTH];

    rd_state_e         rd_st_q, rd_st_d;
    logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]        rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
    logic [DW-1:0]     rd_data_q, rd_data_d, rd_line;
    logic              rd_vld_q, rd_vld_d;

    wr_state_e         wr_st_q, wr_st_d;
    logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]        wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic              perr_q, perr_d, wr_we;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dma_rd_addr[C_M_AXI_ADDR_WIDTH-1:MEM_AW+6], dma_rd_addr[5:0],
                                dma_wr_addr[C_M_AXI_ADDR_WIDTH-1:MEM_AW+6], dma_wr_addr[5:0]};

    // Sampled before this edge's write lands, so a same-line collision returns old data.
    assign rd_line = mem[rd_idx_q];

    always_comb begin
        rd_st_d   = rd_st_q;
        rd_idx_d  = rd_idx_q;
        rd_len_d  = rd_len_q;
        rd_cnt_d  = rd_cnt_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = rd_vld_q;
        case (rd_st_q)
            R_IDLE: if (dma_rd_req) begin
                rd_idx_d = dma_rd_addr[MEM_AW+5:6];
                rd_len_d = dma_rd_len;
                rd_cnt_d = 8'd0;
                rd_st_d  = R_ACK;
            end
            R_ACK: begin
                rd_data_d = rd_line;
                rd_idx_d  = rd_idx_q + MEM_AW'(1);
                rd_vld_d  = 1'b1;
                rd_st_d   = R_DATA;
            end
            R_DATA: if (dma_rd_data_taken) begin
                if (rd_cnt_q == rd_len_q) begin
                    rd_vld_d = 1'b0;
                    rd_st_d  = R_IDLE;
                end else begin
                    rd_cnt_d  = rd_cnt_q + 8'd1;
                    rd_data_d = rd_line;
                    rd_idx_d  = rd_idx_q + MEM_AW'(1);
                end
            end
            default: rd_st_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st_q   <= R_IDLE;
            rd_idx_q  <= '0;
            rd_len_q  <= '0;
            rd_cnt_q  <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_st_q   <= rd_st_d;
            rd_idx_q  <= rd_idx_d;
            rd_len_q  <= rd_len_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign dma_rd_req_ack    = (rd_st_q == R_ACK);
    assign dma_rd_data       = rd_data_q;
    assign dma_rd_data_valid = rd_vld_q;
    assign dma_rd_data_last  = rd_vld_q && (rd_cnt_q == rd_len_q);

    always_comb begin
        wr_st_d  = wr_st_q;
        wr_idx_d = wr_idx_q;
        wr_len_d = wr_len_q;
        wr_cnt_d = wr_cnt_q;
        perr_d   = perr_q;
        wr_we    = 1'b0;
        case (wr_st_q)
            W_IDLE: if (dma_wr_req) begin
                wr_idx_d = dma_wr_addr[MEM_AW+5:6];
                wr_len_d = dma_wr_len;
                wr_cnt_d = 8'd0;
                wr_st_d  = W_ACK;
            end
            W_ACK: wr_st_d = W_DATA;
            W_DATA: if (dma_wr_wvalid) begin
                wr_we = 1'b1;
                // Beat count governs completion; a misplaced last only flags the error.
                if (dma_wr_data_last != (wr_cnt_q == wr_len_q)) perr_d = 1'b1;
                if (wr_cnt_q == wr_len_q) begin
                    wr_st_d = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q + 8'd1;
                    wr_idx_d = wr_idx_q + MEM_AW'(1);
                end
            end
            W_RESP: if (dma_wr_bready) wr_st_d = W_IDLE;
            default: wr_st_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st_q  <= W_IDLE;
            wr_idx_q <= '0;
            wr_len_q <= '0;
            wr_cnt_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            wr_st_q  <= wr_st_d;
            wr_idx_q <= wr_idx_d;
            wr_len_q <= wr_len_d;
            wr_cnt_q <= wr_cnt_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_we) begin
            for (int k = 0; k < SW; k++) begin
                if (dma_wr_data_strobe[k]) mem[wr_idx_q][8*k +: 8] <= dma_wr_data[8*k +: 8];
            end
        end
    end

    assign dma_wr_req_ack = (wr_st_q == W_ACK);
    assign dma_wr_ready   = (wr_st_q == W_DATA);
    assign dma_wr_done    = (wr_st_q == W_RESP);
    assign proto_err      = perr_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Scoreboard bench for dma_mem_responder: read beats are predicted from a line model
// when each burst is requested and compared as the responder presents them.
module tb_dma_mem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req = 1'b0, rd_ack, rd_valid, rd_last, rd_taken = 1'b0;
    logic [63:0]  rd_addr = '0;
    logic [7:0]   rd_len = '0;
    logic [511:0] rd_data;
    logic         wr_req = 1'b0, wr_ack, wr_wvalid = 1'b0, wr_last = 1'b0, wr_ready;
    logic         wr_bready = 1'b0, wr_done, perr;
    logic [63:0]  wr_addr = '0, wr_strb = '0;
    logic [7:0]   wr_len = '0;
    logic [511:0] wr_data = '0;

    logic [511:0] mdl [1024];
    logic [512:0] q [$];
    logic [511:0] wd [4];
    logic [63:0]  ws [4];
    int nchk = 0, nfail = 0;

    dma_mem_responder dut (
        .clk(clk), .rst(rst),
        .dma_rd_req(rd_req), .dma_rd_addr(rd_addr), .dma_rd_len(rd_len),
        .dma_rd_req_ack(rd_ack), .dma_rd_data(rd_data), .dma_rd_data_valid(rd_valid),
        .dma_rd_data_last(rd_last), .dma_rd_data_taken(rd_taken),
        .dma_wr_req(wr_req), .dma_wr_addr(wr_addr), .dma_wr_len(wr_len),
        .dma_wr_req_ack(wr_ack), .dma_wr_data(wr_data), .dma_wr_wvalid(wr_wvalid),
        .dma_wr_data_strobe(wr_strb), .dma_wr_data_last(wr_last), .dma_wr_ready(wr_ready),
        .dma_wr_bready(wr_bready), .dma_wr_done(wr_done), .proto_err(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tk(input int mode, input int t);
        return (mode == 0) ? 1'b1 : (t % 3 == 0);
    endfunction

    task automatic rd_burst(input logic [63:0] a, input int len, input int mode, input int abort_at);
        int n, k, t;
        logic [9:0] li;
        li = a[15:6];
        for (int i = 0; i <= len; i++) begin
            q.push_back({(i == len), mdl[li]});
            li++;
        end
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = a; rd_len = 8'(len);
        n = 0;
        @(negedge clk);
        while (!rd_ack && n < 20) begin n++; @(negedge clk); end
        chk("rd_ack_lat", 512'(n), 512'(1));
        chk("rd_vld_at_ack", 512'(rd_valid), 512'(0));
        @(posedge clk); #1;
        rd_req = 1'b0; t = 0; rd_taken = tk(mode, 0);
        @(negedge clk);
        chk("rd_ack_pulse", 512'(rd_ack), 512'(0));
        chk("rd_vld_lat", 512'(rd_valid), 512'(1));
        k = 0; n = 0;
        while (k <= len && n < 200) begin
            if (k == abort_at) begin
                rst = 1'b1; #1;
                chk("rst_vld", 512'(rd_valid), 512'(0));
                chk("rst_last", 512'(rd_last), 512'(0));
                chk("rst_ack", 512'(rd_ack), 512'(0));
                chk("rst_perr", 512'(perr), 512'(0));
                q.delete();
                @(posedge clk); #1;
                rst = 1'b0; rd_taken = 1'b0;
                return;
            end
            if (!rd_valid) chk("rd_vld", 512'(rd_valid), 512'(1));
            else if (q.size() == 0) chk("rd_extra_beat", 512'(1), 512'(0));
            else begin
                chk("rd_data", rd_data, q[0][511:0]);
                chk("rd_last", 512'(rd_last), 512'(q[0][512]));
                if (rd_taken) begin void'(q.pop_front()); k++; end
            end
            if (k <= len) begin
                @(posedge clk); #1;
                t++; rd_taken = tk(mode, t);
                @(negedge clk);
                n++;
            end
        end
        chk("rd_beats", 512'(k), 512'(len + 1));
        @(posedge clk); #1;
        rd_taken = 1'b0;
        @(negedge clk);
        chk("rd_end_vld", 512'(rd_valid), 512'(0));
        chk("rd_end_last", 512'(rd_last), 512'(0));
    endtask

    task automatic wr_burst(input logic [63:0] a, input int len, input int last_idx, input int bdelay);
        int n;
        logic [9:0] li;
        li = a[15:6];
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = a; wr_len = 8'(len);
        n = 0;
        @(negedge clk);
        while (!wr_ack && n < 20) begin n++; @(negedge clk); end
        chk("wr_ack_lat", 512'(n), 512'(1));
        @(posedge clk); #1;
        wr_req = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            wr_wvalid = 1'b1; wr_data = wd[i]; wr_strb = ws[i]; wr_last = (i == last_idx);
            for (int b = 0; b < 64; b++) if (ws[i][b]) mdl[li][8*b +: 8] = wd[i][8*b +: 8];
            li++;
            n = 0;
            @(negedge clk);
            while (!wr_ready && n < 20) begin n++; @(negedge clk); end
            chk("wr_ready", 512'(wr_ready), 512'(1));
        end
        @(posedge clk); #1;
        wr_wvalid = 1'b0; wr_last = 1'b0; wr_strb = '0;
        for (int c = 0; c < bdelay; c++) begin
            @(negedge clk);
            chk("wr_done_hold", 512'(wr_done), 512'(1));
            chk("wr_rdy_off", 512'(wr_ready), 512'(0));
        end
        @(posedge clk); #1; wr_bready = 1'b1;
        @(posedge clk); #1; wr_bready = 1'b0;
        @(negedge clk);
        chk("wr_done_clr", 512'(wr_done), 512'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_ack", 512'(rd_ack), 512'(0));
        chk("rst_rd_valid", 512'(rd_valid), 512'(0));
        chk("rst_rd_last", 512'(rd_last), 512'(0));
        chk("rst_rd_data", rd_data, 512'(0));
        chk("rst_wr_ack", 512'(wr_ack), 512'(0));
        chk("rst_wr_ready", 512'(wr_ready), 512'(0));
        chk("rst_wr_done", 512'(wr_done), 512'(0));
        chk("rst_perr", 512'(perr), 512'(0));
        @(posedge clk); #1; rst = 1'b0;

        // Preload lines 0..3 and 1023 through the write channel.
        wd[0] = {64{8'hA0}}; wd[1] = {64{8'hA1}}; wd[2] = {64{8'hA2}}; wd[3] = {64{8'hA3}};
        for (int i = 0; i < 4; i++) ws[i] = '1;
        wr_burst(64'h0, 3, 3, 1);
        wd[0] = {64{8'hEE}};
        wr_burst(64'd1023 << 6, 0, 0, 1);

        rd_burst(64'h0, 3, 0, -1);
        rd_burst(64'h0, 3, 1, -1);

        wd[0] = {64{8'h5B}}; ws[0] = 64'h0000_0000_0000_00FF;
        wd[1] = {64{8'hC3}}; ws[1] = '1;
        wr_burst(64'h40, 1, 1, 3);
        rd_burst(64'h40, 1, 0, -1);
        chk("perr_clean", 512'(perr), 512'(0));

        wd[0] = {64{8'h44}}; ws[0] = '1;
        wd[1] = {64{8'h55}}; ws[1] = '1;
        wr_burst(64'h80, 1, 0, 1);
        chk("perr_set", 512'(perr), 512'(1));
        rd_burst(64'h80, 1, 1, -1);

        // Read wrapping 1023 -> 0 while line 0 is overwritten on the same edge it loads.
        wd[0] = {64{8'h77}}; ws[0] = '1;
        begin
            logic [511:0] old0;
            old0 = mdl[0];
            fork
                rd_burst(64'd1023 << 6, 1, 0, -1);
                wr_burst(64'h0, 0, 0, 1);
            join
            chk("coll_model_upd", mdl[0], {64{8'h77}});
            chk("coll_old_nonnew", 512'(old0 != {64{8'h77}}), 512'(1));
        end
        rd_burst(64'h0, 0, 0, -1);

        rd_burst(64'h0, 3, 0, 2);
        chk("post_rst_vld", 512'(rd_valid), 512'(0));
        rd_burst(64'h0, 3, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
